// File: rtl/sdram_frame_reader.sv
// Frame-buffer read client: single-word SDRAM reads into a 2^FIFO_AW x 128b FIFO, unpacked LSB-first into 16b pixels; pixel valid 1 cycle after ack.
// Backpressure: ipix_ready stalls the pixel stream, a full FIFO stops new requests; SDRAM_FRAME_READER_UNDERRUN_CNT_EN builds the underrun counter.
module sdram_frame_reader #(
  parameter logic [21:0] BASE_ADDR   = 22'd0,
  parameter int          FRAME_WORDS = 48000,
  parameter int          FIFO_AW     = 4
) (
  input  logic         iclk,
  input  logic         ireset,
  input  logic         ienable,
  input  logic         iframe_start,
  output logic         oread_req,
  output logic [21:0]  oread_address,
  input  logic [127:0] iread_data,
  input  logic         iread_ack,
  output logic [15:0]  opix_data,
  output logic         opix_valid,
  input  logic         ipix_ready,
  output logic         ounderrun,
  output logic [15:0]  ounderrun_cnt
);

  localparam int WP_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int CNT_W = FIFO_AW + 1;
  localparam logic [WP_W-1:0]  WP_LAST = WP_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [21:0]        addr_q, addr_d;
  logic [WP_W-1:0]    wptr_q, wptr_d;
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pix_q, pix_d;
  logic               underrun_q, underrun_d;
  logic               push, pop, accept;
  logic [127:0]       mem [2**FIFO_AW];
  logic [127:0]       head_word;

  assign head_word     = mem[rd_q];
  assign opix_valid    = (cnt_q != '0);
  assign opix_data     = opix_valid ? head_word[{pix_q, 4'b0000} +: 16] : 16'd0;
  assign oread_req     = req_q;
  assign oread_address = addr_q;
  assign ounderrun     = underrun_q;

  always_ff @(posedge iclk) begin
    if (ireset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wptr_d     = wptr_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    push       = 1'b0;
    accept     = opix_valid & ipix_ready;
    pop        = accept & (pix_q == 3'd7);
    underrun_d = ienable & ipix_ready & ~opix_valid;

    case (state_q)
      IDLE: begin
        // No request on a restart edge: word_ptr is being cleared this cycle.
        if (!iframe_start && ienable && (cnt_q < DEPTH)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = BASE_ADDR + 22'(wptr_q);
        end
      end
      REQ: begin
        if (iread_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          push    = ~iframe_start;
        end else if (iframe_start) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (iread_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (iframe_start) begin
      wptr_d = '0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      pix_d  = '0;
    end else begin
      if (accept) pix_d = pix_q + 3'd1;
      if (pop)    rd_d  = rd_q + FIFO_AW'(1);
      if (push) begin
        wr_d   = wr_q + FIFO_AW'(1);
        wptr_d = (wptr_q == WP_LAST) ? '0 : wptr_q + WP_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      req_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      wptr_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      wptr_q     <= wptr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge iclk) begin
    if (push) mem[wr_q] <= iread_data;
  end

`ifdef SDRAM_FRAME_READER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  // Only ireset clears the count so it survives frame restarts.
  always_ff @(posedge iclk) begin
    if (ireset)                                 ucnt_q <= 16'd0;
    else if (underrun_q && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end

  assign ounderrun_cnt = ucnt_q;
`else
  assign ounderrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Bench for sdram_frame_reader: controller model, pixel-queue reference model, directed phases.
module tb_sdram_frame_reader;

  localparam logic [21:0] BASE = 22'h100;
  localparam int          FW   = 4;
`ifdef SDRAM_FRAME_READER_UNDERRUN_CNT_EN
  localparam int UCNT_EN = 1;
`else
  localparam int UCNT_EN = 0;
`endif

  logic         iclk = 1'b0;
  logic         ireset = 1'b1;
  logic         ienable = 1'b0;
  logic         iframe_start = 1'b0;
  logic         oread_req;
  logic [21:0]  oread_address;
  logic [127:0] iread_data = '0;
  logic         iread_ack = 1'b0;
  logic [15:0]  opix_data;
  logic         opix_valid;
  logic         ipix_ready = 1'b0;
  logic         ounderrun;
  logic [15:0]  ounderrun_cnt;

  sdram_frame_reader #(.BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_AW(4)) dut (
    .iclk(iclk), .ireset(ireset), .ienable(ienable), .iframe_start(iframe_start),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack),
    .opix_data(opix_data), .opix_valid(opix_valid), .ipix_ready(ipix_ready),
    .ounderrun(ounderrun), .ounderrun_cnt(ounderrun_cnt)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] gen_word(input int s);
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(s * 8 + j);
    return w;
  endfunction

  // Controller model: acks ack_delay cycles after it sees a request.
  int ctrl_en = 1;
  int ack_delay = 3;
  int seq = 0;
  int wc = 0;
  always @(negedge iclk) begin
    if (ireset || ctrl_en == 0 || !oread_req) begin
      iread_ack = 1'b0;
      wc = 0;
    end else begin
      wc++;
      if (wc >= ack_delay) begin
        iread_ack  = 1'b1;
        iread_data = gen_word(seq);
        seq++;
        wc = 0;
      end else begin
        iread_ack = 1'b0;
      end
    end
  end

  // Reference model: pixels queued in display order, updated from inputs sampled at each edge.
  logic [15:0] pq[$];
  logic [21:0] addr_log[$];
  int m_wp = 0;
  bit m_drop = 0;
  bit m_uexp = 0;
  int m_ucnt = 0;
  bit m_prev_req = 0;
  int words_pre;
  bit empty_pre;

  always @(posedge iclk) begin
    #1;
    if (ireset) begin
      pq.delete();
      m_wp = 0; m_drop = 0; m_uexp = 0; m_ucnt = 0;
    end else begin
      words_pre = (pq.size() + 7) / 8;
      empty_pre = (pq.size() == 0);
      if (m_uexp && m_ucnt != 16'hFFFF) m_ucnt++;
      m_uexp = ienable && ipix_ready && empty_pre;
      if (iframe_start) begin
        pq.delete();
        m_wp = 0;
        if (m_prev_req && !iread_ack) m_drop = 1;
        else if (iread_ack)           m_drop = 0;
      end else begin
        if (!empty_pre && ipix_ready) void'(pq.pop_front());
        if (m_prev_req && iread_ack) begin
          if (m_drop) m_drop = 0;
          else begin
            chk("fifo_space_at_ack", 32'(words_pre < 16), 1);
            for (int j = 0; j < 8; j++) pq.push_back(iread_data[16*j +: 16]);
            m_wp = (m_wp == FW - 1) ? 0 : m_wp + 1;
          end
        end
      end
      if (m_prev_req && iread_ack) chk("req_low_after_ack", 32'(oread_req), 0);
      if (!m_prev_req && oread_req) begin
        chk("req_address", 32'(oread_address), 32'(BASE + 22'(m_wp)));
        addr_log.push_back(oread_address);
      end
    end
    chk("pix_valid", 32'(opix_valid), 32'(pq.size() != 0));
    if (opix_valid && pq.size() != 0) chk("pix_data", 32'(opix_data), 32'(pq[0]));
    chk("underrun", 32'(ounderrun), 32'(m_uexp));
    chk("underrun_cnt", 32'(ounderrun_cnt), (UCNT_EN != 0) ? 32'(m_ucnt) : 32'd0);
    m_prev_req = oread_req;
  end

  logic [21:0] exp_addr [6];
  int n, pulses, snap;

  initial begin
    exp_addr[0] = 22'h100; exp_addr[1] = 22'h101; exp_addr[2] = 22'h102;
    exp_addr[3] = 22'h103; exp_addr[4] = 22'h100; exp_addr[5] = 22'h101;

    // Reset values.
    repeat (3) @(negedge iclk);
    chk("rst_req", 32'(oread_req), 0);
    chk("rst_addr", 32'(oread_address), 32'h100);
    chk("rst_valid", 32'(opix_valid), 0);
    chk("rst_data", 32'(opix_data), 0);
    chk("rst_underrun", 32'(ounderrun), 0);
    chk("rst_ucnt", 32'(ounderrun_cnt), 0);
    ireset = 1'b0;

    // Fill the FIFO with no consumer.
    ienable = 1'b1;
    n = 0;
    while (pq.size() != 128 && n < 400) begin @(negedge iclk); n++; end
    chk("fill_timeout", 32'(n < 400), 1);
    repeat (20) begin
      @(negedge iclk);
      chk("full_no_req", 32'(oread_req), 0);
    end
    chk("addr_log_len", 32'(addr_log.size() >= 6), 1);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      chk($sformatf("wrap_addr%0d", i), 32'(addr_log[i]), 32'(exp_addr[i]));
    chk("full_head_pix", 32'(opix_data), 32'h0000);

    // Stream out; ack delay 7 lines an ack up with a k=7 pop at 15 words.
    ack_delay = 7;
    ipix_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("seq_pix%0d", k), 32'(opix_data), 32'(k));
      @(negedge iclk);
    end

    // Restart while a request is in flight.
    ack_delay = 5;
    n = 0;
    while (oread_req && n < 100) begin @(negedge iclk); n++; end
    while (!oread_req && n < 100) begin @(negedge iclk); n++; end
    chk("req_wait_timeout", 32'(n < 100), 1);
    iframe_start = 1'b1;
    @(negedge iclk);
    iframe_start = 1'b0;
    chk("flush_valid", 32'(opix_valid), 0);
    n = 0;
    while (oread_req && n < 100) begin @(negedge iclk); n++; end
    while (!oread_req && n < 100) begin
      chk("discard_not_shown", 32'(opix_valid), 0);
      @(negedge iclk); n++;
    end
    chk("restart_timeout", 32'(n < 100), 1);
    chk("restart_addr", 32'(oread_address), 32'h100);
    chk("restart_valid", 32'(opix_valid), 0);
    snap = seq;
    n = 0;
    while (!opix_valid && n < 100) begin @(negedge iclk); n++; end
    chk("restart_data_timeout", 32'(n < 100), 1);
    chk("restart_first_pix", 32'(opix_data), 32'(16'(snap * 8)));

    // Mixed traffic: stalls, varying latency, occasional restarts and disables.
    for (int c = 0; c < 600; c++) begin
      @(negedge iclk);
      ipix_ready   = ($urandom_range(0, 3) != 0);
      ack_delay    = $urandom_range(1, 6);
      iframe_start = ($urandom_range(0, 49) == 0);
      ienable      = ($urandom_range(0, 15) != 0);
    end
    iframe_start = 1'b0;

    // Underrun burst of exactly 5 cycles from a fresh reset.
    ctrl_en = 0;
    ipix_ready = 1'b0;
    ireset = 1'b1;
    repeat (2) @(negedge iclk);
    ireset = 1'b0;
    ienable = 1'b1;
    ipix_ready = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge iclk);
      if (ounderrun) pulses++;
      if (i == 5) ipix_ready = 1'b0;
    end
    chk("underrun_pulses", 32'(pulses), 5);
    chk("underrun_cnt_final", 32'(ounderrun_cnt), (UCNT_EN != 0) ? 32'd5 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
